cim_gemm_sequencer: RTL and testbench

//  Command-driven sequencer for one 1024x8b Basic_GeMM_CIM macro: streams weights into the macro (LOAD), then issues CIM

---
 rtl/cim_gemm_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_cim_gemm_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_gemm_sequencer.sv
// cim_gemm_sequencer
//   Command-driven sequencer for one 1024x8b GeMM CIM macro. A LOAD command
//   streams weight bytes into consecutive macro addresses. A COMPUTE command
//   issues one CIM pass per activation vector and collects the 8x8b results,
//   tagged with {tile,sub}, into a small first-word-fall-through result FIFO.
//   This block drives every macro control pin.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_*                      command: op (0=LOAD,1=COMPUTE), base, tile, len
//   w_valid/w_ready/w_data     weight byte stream (LOAD only)
//   act_valid/act_ready/act_data  activation stream (COMPUTE only)
//   res_valid/res_ready/res_data/res_sub  result FIFO head
//   busy, done                 state!=IDLE, one-cycle completion pulse
//   mac_*                      macro controls / address / data, mac_cim_out back
module cim_gemm_sequencer #(
  parameter int RES_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [9:0]  cmd_base,
  input  logic [2:0]  cmd_tile,
  input  logic [10:0] cmd_len,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [7:0]  w_data,
  input  logic        act_valid,
  output logic        act_ready,
  input  logic [31:0] act_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [4:0]  res_sub,
  output logic        busy,
  output logic        done,
  output logic        mac_cs,
  output logic        mac_web,
  output logic        mac_cimeb,
  output logic [9:0]  mac_a,
  output logic [7:0]  mac_d,
  output logic [31:0] mac_cim_in,
  input  logic [63:0] mac_cim_out
);

  localparam int PW = $clog2(RES_FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CMP, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [9:0]    base_q, base_d;
  logic [2:0]    tile_q, tile_d;
  logic [10:0]   len_q, len_d;
  logic [10:0]   cnt_q, cnt_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          w_ready_q, w_ready_d;
  logic          act_ready_q, act_ready_d;
  logic          mac_cs_q, mac_cs_d;
  logic          mac_web_q, mac_web_d;
  logic          mac_cimeb_q, mac_cimeb_d;
  logic [9:0]    mac_a_q, mac_a_d;
  logic [7:0]    mac_d_q, mac_d_d;
  logic [31:0]   mac_cim_in_q, mac_cim_in_d;
  // [0] = issue cycle, [1] = capture cycle (mac_cim_out sampled at its end)
  logic [1:0]      vld_pipe_q, vld_pipe_d;
  logic [1:0][4:0] tag_pipe_q, tag_pipe_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          res_valid_q, res_valid_d;
  logic [63:0]   res_data_q, res_data_d;
  logic [4:0]    res_sub_q, res_sub_d;
  logic [68:0]   mem_q [RES_FIFO_DEPTH];

  logic          w_hs, a_hs, push, pop;
  logic [10:0]   cnt_inc;
  logic [2:0]    cur_tile;
  logic [4:0]    cur_tag;
  logic [68:0]   push_word, head;

  always_comb begin
    w_hs      = w_ready_q & w_valid;
    a_hs      = act_ready_q & act_valid;
    push      = vld_pipe_q[1];
    pop       = res_valid_q & res_ready;
    cnt_inc   = cnt_q + 11'd1;
    cur_tile  = tile_q + cnt_q[4:2];
    cur_tag   = {cur_tile, cnt_q[1:0]};
    push_word = {tag_pipe_q[1], mac_cim_out};

    state_d      = state_q;
    base_d       = base_q;
    tile_d       = tile_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    mac_cs_d     = 1'b0;
    mac_web_d    = 1'b1;
    mac_cimeb_d  = 1'b1;
    mac_a_d      = mac_a_q;
    mac_d_d      = mac_d_q;
    mac_cim_in_d = mac_cim_in_q;

    vld_pipe_d    = {vld_pipe_q[0], a_hs};
    tag_pipe_d[1] = tag_pipe_q[0];
    tag_pipe_d[0] = a_hs ? cur_tag : tag_pipe_q[0];

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_len == 11'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = cmd_op ? S_CMP : S_LOAD;
            base_d  = cmd_base;
            tile_d  = cmd_tile;
            len_d   = cmd_len;
            cnt_d   = 11'd0;
          end
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          cnt_d     = cnt_inc;
          mac_cs_d  = 1'b1;
          mac_web_d = 1'b0;
          mac_a_d   = base_q + cnt_q[9:0];
          mac_d_d   = w_data;
          // done rises together with the final write cycle
          if (cnt_inc == len_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_CMP: begin
        if (a_hs) begin
          cnt_d        = cnt_inc;
          mac_a_d      = {2'b00, cur_tile, 3'b000, cnt_q[1:0]};
          mac_cim_in_d = act_data;
          if (cnt_inc == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // last vector is being pushed and nothing is left in the issue slot
        if (push && !vld_pipe_q[0]) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Keep the macro in CIM mode for both the issue and capture cycles.
    if (vld_pipe_d != 2'b00) begin
      mac_cs_d    = 1'b1;
      mac_web_d   = 1'b1;
      mac_cimeb_d = 1'b0;
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    // The next head bypasses the array when it is the word being pushed now.
    head = (push && (wr_ptr_q == rd_ptr_d)) ? push_word : mem_q[rd_ptr_d];
    res_valid_d = (count_d != '0);
    res_data_d  = res_data_q;
    res_sub_d   = res_sub_q;
    if (res_valid_d) {res_sub_d, res_data_d} = head;

    // Credit covers queued results plus vectors still in the macro pipe.
    act_ready_d = (state_d == S_CMP) &&
                  ((int'(count_d) + int'(vld_pipe_d[0]) + int'(vld_pipe_d[1])) < RES_FIFO_DEPTH);
    w_ready_d   = (state_d == S_LOAD);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      tile_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      w_ready_q    <= 1'b0;
      act_ready_q  <= 1'b0;
      mac_cs_q     <= 1'b0;
      mac_web_q    <= 1'b1;
      mac_cimeb_q  <= 1'b1;
      mac_a_q      <= '0;
      mac_d_q      <= '0;
      mac_cim_in_q <= '0;
      vld_pipe_q   <= '0;
      tag_pipe_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_sub_q    <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      tile_q       <= tile_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      w_ready_q    <= w_ready_d;
      act_ready_q  <= act_ready_d;
      mac_cs_q     <= mac_cs_d;
      mac_web_q    <= mac_web_d;
      mac_cimeb_q  <= mac_cimeb_d;
      mac_a_q      <= mac_a_d;
      mac_d_q      <= mac_d_d;
      mac_cim_in_q <= mac_cim_in_d;
      vld_pipe_q   <= vld_pipe_d;
      tag_pipe_q   <= tag_pipe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_sub_q    <= res_sub_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign w_ready    = w_ready_q;
  assign act_ready  = act_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_sub    = res_sub_q;
  assign mac_cs     = mac_cs_q;
  assign mac_web    = mac_web_q;
  assign mac_cimeb  = mac_cimeb_q;
  assign mac_a      = mac_a_q;
  assign mac_d      = mac_d_q;
  assign mac_cim_in = mac_cim_in_q;

endmodule

// File: tb/tb_cim_gemm_sequencer.sv
// Directed bench for cim_gemm_sequencer with a behavioural macro model and a
// result scoreboard (expected words queued when activations are driven).
module tb_cim_gemm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [9:0]  cmd_base;
  logic [2:0]  cmd_tile;
  logic [10:0] cmd_len;
  logic        w_valid, w_ready;
  logic [7:0]  w_data;
  logic        act_valid, act_ready;
  logic [31:0] act_data;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic [4:0]  res_sub;
  logic        busy, done;
  logic        mac_cs, mac_web, mac_cimeb;
  logic [9:0]  mac_a;
  logic [7:0]  mac_d;
  logic [31:0] mac_cim_in;
  logic [63:0] mac_cim_out;

  int total = 0;
  int bad   = 0;
  logic [68:0] exp_q [$];

  cim_gemm_sequencer #(.RES_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_tile(cmd_tile), .cmd_len(cmd_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sub(res_sub),
    .busy(busy), .done(done),
    .mac_cs(mac_cs), .mac_web(mac_web), .mac_cimeb(mac_cimeb),
    .mac_a(mac_a), .mac_d(mac_d), .mac_cim_in(mac_cim_in), .mac_cim_out(mac_cim_out)
  );

  always #5 clk = ~clk;

  // Macro model: byte-wide weight RAM; a CIM cycle registers one result
  // lane per j: ((sum of 4 input bytes) * 2 * w[a+j]) >> 8.
  logic [7:0]  wmem [1024];
  logic [63:0] cim_r;

  function automatic logic [63:0] macro_f(input logic [9:0] a, input logic [31:0] x);
    logic [63:0] r;
    logic [9:0]  s;
    logic [19:0] p;
    logic [9:0]  aj;
    s = 10'(x[7:0]) + 10'(x[15:8]) + 10'(x[23:16]) + 10'(x[31:24]);
    for (int j = 0; j < 8; j++) begin
      aj = a + 10'(j);
      p  = 20'(s) * 20'd2 * 20'(wmem[aj]);
      r[j*8 +: 8] = p[15:8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (mac_cs && !mac_web) wmem[mac_a] <= mac_d;
    if (mac_cs && !mac_cimeb) cim_r <= macro_f(mac_a, mac_cim_in);
  end
  assign mac_cim_out = cim_r;

  // Expected result with every weight equal to 2.
  function automatic logic [63:0] exp_f(input logic [31:0] x);
    logic [11:0] s;
    logic [7:0]  v;
    s = 12'(x[7:0]) + 12'(x[15:8]) + 12'(x[23:16]) + 12'(x[31:24]);
    v = 8'((s * 12'd4) >> 8);
    return {8{v}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: result monitor at the falling edge, then step past the rising edge.
  task automatic tick();
    logic [68:0] e;
    @(negedge clk);
    if (rst_n && res_valid && res_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL res_unexpected: got sub %0h data %0h", res_sub, res_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("res_sub", 64'(res_sub), 64'(e[68:64]));
        chk("res_data", res_data, e[63:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_sub", 64'(res_sub), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_act_ready", 64'(act_ready), 64'd0);
    chk("rst_mac_cs", 64'(mac_cs), 64'd0);
    chk("rst_mac_web", 64'(mac_web), 64'd1);
    chk("rst_mac_cimeb", 64'(mac_cimeb), 64'd1);
    chk("rst_mac_a", 64'(mac_a), 64'd0);
    chk("rst_mac_d", 64'(mac_d), 64'd0);
    chk("rst_mac_cim_in", 64'(mac_cim_in), 64'd0);
  endtask

  task automatic send_cmd(input logic op, input logic [9:0] base, input logic [2:0] tile,
                          input logic [10:0] len);
    chk("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_tile = tile; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_w();
    logic hs;
    int n = 0;
    do begin
      hs = w_ready;
      tick();
      n++;
    end while (!hs && n < 200);
    chk("w_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_act(input logic [2:0] tile, input int k, input logic [31:0] data,
                          output int n);
    logic        hs;
    logic [10:0] kk;
    logic [2:0]  t;
    logic [9:0]  a;
    kk = 11'(k);
    t  = tile + kk[4:2];
    a  = {2'b00, t, 3'b000, kk[1:0]};
    exp_q.push_back({t, kk[1:0], exp_f(data)});
    act_valid = 1'b1; act_data = data;
    n = 0;
    do begin
      hs = act_ready;
      tick();
      n++;
    end while (!hs && n < 200);
    act_valid = 1'b0;
    chk("act_handshake", 64'(hs), 64'd1);
    chk("cmp_mac_a", 64'(mac_a), 64'(a));
    chk("cmp_mac_cs", 64'(mac_cs), 64'd1);
    chk("cmp_mac_web", 64'(mac_web), 64'd1);
    chk("cmp_mac_cimeb", 64'(mac_cimeb), 64'd0);
    chk("cmp_mac_cim_in", 64'(mac_cim_in), 64'(data));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic drain(input string tag);
    repeat (8) tick();
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    logic [9:0]  a;
    logic [7:0]  b;
    logic [31:0] x;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_tile = '0; cmd_len = '0;
    w_valid = 1'b0; w_data = '0; act_valid = 1'b0; act_data = '0; res_ready = 1'b0;
    repeat (3) tick();
    check_rst();
    rst_n = 1'b1;
    tick();

    // LOAD wrapping the top of the address space
    send_cmd(1'b0, 10'd1020, 3'd0, 11'd8);
    chk("load_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      b = 8'(i + 1);
      a = 10'(1020 + i);
      w_valid = 1'b1; w_data = b;
      wait_w();
      chk("load_cs", 64'(mac_cs), 64'd1);
      chk("load_web", 64'(mac_web), 64'd0);
      chk("load_cimeb", 64'(mac_cimeb), 64'd1);
      chk("load_a", 64'(mac_a), 64'(a));
      chk("load_d", 64'(mac_d), 64'(b));
      chk("load_done", 64'(done), (i == 7) ? 64'd1 : 64'd0);
    end
    w_valid = 1'b0;
    tick();
    chk("load_cs_after", 64'(mac_cs), 64'd0);
    chk("load_done_after", 64'(done), 64'd0);
    chk("load_busy_after", 64'(busy), 64'd0);
    chk("load_cmd_ready_after", 64'(cmd_ready), 64'd1);

    // Fill all weights with 2
    send_cmd(1'b0, 10'd0, 3'd0, 11'd1024);
    w_valid = 1'b1; w_data = 8'd2;
    repeat (1024) wait_w();
    w_valid = 1'b0;
    chk("fill_done", 64'(done), 64'd1);
    tick();

    // COMPUTE tile 0, 4 vectors of 16s: every lane 8'h01, subs 0..3
    res_ready = 1'b1;
    send_cmd(1'b1, 10'd0, 3'd0, 11'd4);
    for (int k = 0; k < 4; k++) send_act(3'd0, k, {4{8'd16}}, n);
    wait_done("cmp4_done");
    drain("cmp4_drain");

    // COMPUTE tile 7 wrapping to tile 0, back to back
    send_cmd(1'b1, 10'd0, 3'd7, 11'd8);
    for (int k = 0; k < 8; k++) begin
      x = {8'hFF, 8'hFF, 8'(k * 20), 8'(k * 10)};
      send_act(3'd7, k, x, n);
      chk("b2b_wait", 64'(n), 64'd1);
    end
    wait_done("cmp8_done");
    drain("cmp8_drain");

    // Backpressure: credit stops acceptance at FIFO depth
    res_ready = 1'b0;
    send_cmd(1'b1, 10'd0, 3'd2, 11'd10);
    for (int k = 0; k < 4; k++) send_act(3'd2, k, 32'h0102_0304 * (k + 1), n);
    chk("bp_act_ready_drop", 64'(act_ready), 64'd0);
    repeat (4) tick();
    chk("bp_act_ready_held", 64'(act_ready), 64'd0);
    chk("bp_res_valid", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    for (int k = 4; k < 10; k++) send_act(3'd2, k, 32'h0102_0304 * (k + 1), n);
    wait_done("bp_done");
    drain("bp_drain");

    // Reset with two results queued
    res_ready = 1'b0;
    send_cmd(1'b1, 10'd0, 3'd0, 11'd6);
    send_act(3'd0, 0, 32'h1111_1111, n);
    send_act(3'd0, 1, 32'h2222_2222, n);
    repeat (3) tick();
    chk("rst_mid_res_valid", 64'(res_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    check_rst();
    exp_q.delete();
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_done", 64'(done), 64'd0);
      chk("rst_no_result", 64'(res_valid), 64'd0);
    end

    // Zero-length commands
    send_cmd(1'b0, 10'd5, 3'd0, 11'd0);
    chk("zl_load_done", 64'(done), 64'd1);
    chk("zl_load_busy", 64'(busy), 64'd0);
    chk("zl_load_cs", 64'(mac_cs), 64'd0);
    chk("zl_load_w_ready", 64'(w_ready), 64'd0);
    tick();
    chk("zl_load_done_clear", 64'(done), 64'd0);
    send_cmd(1'b1, 10'd0, 3'd3, 11'd0);
    chk("zl_cmp_done", 64'(done), 64'd1);
    chk("zl_cmp_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("zl_cmp_cs", 64'(mac_cs), 64'd0);
    chk("zl_cmp_act_ready", 64'(act_ready), 64'd0);
    tick();
    chk("zl_cmp_done_clear", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
